// File: rtl/mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// mem_copy_initiator : word-by-word block copier acting as a bus master on the
//                      valid/ready memory interface (one read, then one write).
// Revision: 1.0
// ============================================================================
module mem_copy_initiator #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR     = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             pend_q, pend_d;
  logic             aborted_q, aborted_d;
  logic [LEN_W-1:0] wdone_q, wdone_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       strb_q, strb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
      wdone_q   <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
      wdone_q   <= wdone_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    aborted_d  = aborted_q;
    wdone_d    = wdone_q;
    abort_seen = pend_q | abort;
    pend_d     = pend_q | (abort && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = src_addr;
          dst_d     = dst_addr;
          cnt_d     = len_words;
          wdone_d   = '0;
          aborted_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = (len_words != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        // An abort seen around the read drops this word entirely.
        if (abort_seen) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (mem_ready) begin
          wdone_d = wdone_q + C_ONE;
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - C_ONE;
          if (cnt_q == C_ONE) begin
            state_d = S_DONE;
          end else if (abort_seen) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: state_d = S_RD;
      S_DONE: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they are glitch-free.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_RD) || (state_d == S_WR);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = 4'b0000;
    if (state_d == S_RD) begin
      addr_d = {src_d[31:2], 2'b00};
    end else if (state_d == S_WR) begin
      addr_d  = {dst_d[31:2], 2'b00};
      wdata_d = buf_d;
      strb_d  = 4'b1111;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_done = wdone_q;
  assign mem_valid  = valid_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = strb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
// tb_mem_copy_initiator : randomized copies against a timeline model of the
//                         copier, with a parameterizable-latency responder.
// Revision: 1.0
// ============================================================================
module tb_mem_copy_initiator;

  localparam int LEN_W = 16;
  localparam int INF   = 1000000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             abort;
  logic             busy, done, aborted;
  logic [LEN_W-1:0] words_done;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_wstrb;

  mem_copy_initiator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len_words(len_words), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .words_done(words_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Contents of never-written memory, shared by responder and model.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // ---------------- responder ----------------
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] rd_log [$];
  int          resp_n  = 4;
  int          vcnt    = 0;
  int          txn_cnt = 0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end else if (mem_valid) begin
      vcnt++;
      if (vcnt == resp_n) begin
        mem_ready = 1'b1;
        txn_cnt++;
        if (mem_wstrb == 4'b0000) begin
          mem_rdata = rmem.exists(mem_addr) ? rmem[mem_addr] : dflt(mem_addr);
          rd_log.push_back(mem_addr);
        end else begin
          rmem[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      vcnt      = 0;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic             v;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       strb;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] wd;
    logic             ab;
  } rec_t;

  rec_t             exp_q [$];
  logic [31:0]      mmem [logic [31:0]];
  logic [LEN_W-1:0] prev_wd = '0;
  logic             prev_ab = 1'b0;

  function automatic rec_t mk(input logic v, input logic [31:0] a, input logic [31:0] wdat,
                              input logic [3:0] s, input logic b, input logic dn,
                              input logic [LEN_W-1:0] wd, input logic ab);
    rec_t r;
    r.v = v; r.addr = a; r.wdata = wdat; r.strb = s;
    r.busy = b; r.done = dn; r.wd = wd; r.ab = ab;
    return r;
  endfunction

  // Builds the expected per-cycle outputs from cycle 0 (start cycle) to the
  // end of the trailing idle cycles; a = first cycle abort is high (INF = none).
  task automatic plan(input logic [31:0] s_in, input logic [31:0] d_in, input int L,
                      input int N, input int a, input int trail, output int dcyc);
    logic [31:0] s, d, val;
    int P, words, rd_words, w;
    logic ab;
    logic [LEN_W-1:0] wd;
    s = {s_in[31:2], 2'b00};
    d = {d_in[31:2], 2'b00};
    P = 2 * N + 2;
    words = L; rd_words = L; ab = 1'b0;
    dcyc = (L == 0) ? 1 : L * P;
    for (int k = 0; k < L; k++) begin
      if (a <= k * P + N + 1) begin
        words = k; rd_words = k + 1; ab = 1'b1; dcyc = k * P + N + 2;
        break;
      end else if (a <= k * P + 2 * N + 1) begin
        words = k + 1; rd_words = k + 1;
        if (k + 1 < L) begin ab = 1'b1; dcyc = (k + 1) * P; end
        break;
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, prev_wd, prev_ab));
    wd = '0;
    for (w = 0; w < rd_words; w++) begin
      val = mmem.exists(s + 32'(4 * w)) ? mmem[s + 32'(4 * w)] : dflt(s + 32'(4 * w));
      for (int k = 0; k < N; k++) exp_q.push_back(mk(1, s + 32'(4 * w), 0, 4'h0, 1, 0, wd, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, wd, 0));
      if (w < words) begin
        for (int k = 0; k < N; k++) exp_q.push_back(mk(1, d + 32'(4 * w), val, 4'hF, 1, 0, wd, 0));
        mmem[d + 32'(4 * w)] = val;
        wd++;
        if (w + 1 < rd_words) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, wd, 0));
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1, LEN_W'(words), ab));
    for (int k = 0; k < trail; k++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, LEN_W'(words), ab));
    prev_wd = LEN_W'(words);
    prev_ab = ab;
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("busy", busy, r.busy);
      chk("done", done, r.done);
      chk("mem_valid", mem_valid, r.v);
      chk("words_done", words_done, r.wd);
      chk("aborted", aborted, r.ab);
      if (r.v) begin
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_wstrb", mem_wstrb, r.strb);
        if (r.strb == 4'hF) chk("mem_wdata", mem_wdata, r.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int L, input int N,
                          input int a, input bit noise,
                          output int dcyc_meas, output int wd_meas, output int ab_meas);
    int c, nrec, dcyc;
    c = 0; nrec = 1; dcyc = 1;
    dcyc_meas = -1; wd_meas = -1; ab_meas = -1;
    resp_n = N;
    while (c < nrec) begin
      @(posedge clk); #1;
      if (c == 0) begin
        plan(s, d, L, N, a, 2, dcyc);
        nrec      = dcyc + 3;
        src_addr  = s;
        dst_addr  = d;
        len_words = LEN_W'(L);
        start     = 1'b1;
        abort     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (dcyc_meas < 0 && done === 1'b1) begin
          dcyc_meas = c; wd_meas = int'(words_done); ab_meas = int'(aborted);
        end
        start = (noise && c <= dcyc) ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (c >= a && c <= dcyc) abort = 1'b1;
        else abort = (noise && c > dcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          src_addr = $urandom; dst_addr = $urandom; len_words = LEN_W'($urandom);
        end
      end
      c++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int dc, wdm, abm, t0, N, L, a;
    logic [31:0] s, d, r1;
    bit found;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_words_done", words_done, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic 3-word copy with the BRAM-like responder.
    rmem[32'h100] = 32'h11111111; rmem[32'h104] = 32'h22222222; rmem[32'h108] = 32'h33333333;
    mmem[32'h100] = 32'h11111111; mmem[32'h104] = 32'h22222222; mmem[32'h108] = 32'h33333333;
    run_copy(32'h100, 32'h200, 3, 4, INF, 0, dc, wdm, abm);
    chk("t1_done_cycle", dc, 30);
    chk("t1_words_done", wdm, 3);
    chk("t1_aborted", abm, 0);
    chk("t1_dst0", rmem.exists(32'h200) ? rmem[32'h200] : 32'h0, 32'h11111111);
    chk("t1_dst1", rmem.exists(32'h204) ? rmem[32'h204] : 32'h0, 32'h22222222);
    chk("t1_dst2", rmem.exists(32'h208) ? rmem[32'h208] : 32'h0, 32'h33333333);

    // Zero-length copy.
    t0 = txn_cnt;
    run_copy(32'h100, 32'h300, 0, 4, INF, 0, dc, wdm, abm);
    chk("len0_done_cycle", dc, 1);
    chk("len0_words_done", wdm, 0);
    chk("len0_txns", txn_cnt - t0, 0);

    // Start pulses while busy are ignored; then a clean follow-up copy.
    t0 = txn_cnt;
    run_copy(32'h500, 32'h600, 2, 4, INF, 1, dc, wdm, abm);
    chk("busy_start_txns", txn_cnt - t0, 4);
    chk("busy_start_done", dc, 20);
    run_copy(32'h700, 32'h800, 1, 4, INF, 0, dc, wdm, abm);
    chk("after_start_done", dc, 10);

    // Abort during the read of word 2 of 4, then during its write.
    t0 = txn_cnt;
    run_copy(32'h1000, 32'h2000, 4, 4, 12, 0, dc, wdm, abm);
    chk("abort_rd_words", wdm, 1);
    chk("abort_rd_aborted", abm, 1);
    chk("abort_rd_done", dc, 16);
    chk("abort_rd_txns", txn_cnt - t0, 3);
    t0 = txn_cnt;
    run_copy(32'h1000, 32'h2000, 4, 4, 17, 0, dc, wdm, abm);
    chk("abort_wr_words", wdm, 2);
    chk("abort_wr_aborted", abm, 1);
    chk("abort_wr_done", dc, 20);
    chk("abort_wr_txns", txn_cnt - t0, 4);

    // Fast and slow responders.
    run_copy(32'h3000, 32'h3100, 3, 1, INF, 0, dc, wdm, abm);
    chk("n1_done", dc, 12);
    run_copy(32'h3000, 32'h3200, 3, 7, INF, 0, dc, wdm, abm);
    chk("n7_done", dc, 48);

    // Source address wrap-around, with misaligned low bits.
    rd_log.delete();
    run_copy(32'hFFFFFFFE, 32'h4001, 2, 4, INF, 0, dc, wdm, abm);
    chk("wrap_nreads", rd_log.size(), 2);
    r1 = (rd_log.size() > 0) ? rd_log[0] : 32'hDEADBEEF;
    chk("wrap_read0", r1, 32'hFFFFFFFC);
    r1 = (rd_log.size() > 1) ? rd_log[1] : 32'hDEADBEEF;
    chk("wrap_read1", r1, 32'h00000000);

    // Randomized copies, including overlapping regions and random aborts.
    for (int i = 0; i < 40; i++) begin
      N = $urandom_range(1, 7);
      L = $urandom_range(0, 6);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (2 * N + 2) * L + 1) : INF;
      s = $urandom;
      d = ($urandom_range(0, 1) == 0) ? s + 32'($urandom_range(0, 8) * 4) - 32'd16 : $urandom;
      run_copy(s, d, L, N, a, ($urandom_range(0, 1) == 1), dc, wdm, abm);
    end

    // Asynchronous reset in the middle of a write.
    resp_n = 7;
    @(posedge clk); #1;
    src_addr = 32'h5000; dst_addr = 32'h6000; len_words = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (mem_valid === 1'b1 && mem_wstrb === 4'hF) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_mid_reach_wr", found, 1);
    @(posedge clk); #2;
    chk("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", mem_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Bus-master (initiator) side of the valid/ready memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) used by the BRAM controller.
- Copies a block of 32-bit words from a source to a destination address, one read then one write per word.
- Sits beside the CPU as a second master on the memory interface; arbitration is external.
- Also drives the LED/UART MMIO addresses as a plain initiator.

Parameters:
- LEN_W, 16, width of the word-count input and the words_done counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  start request, sampled only in IDLE.
- src_addr  in  32  source byte address; bits[1:0] ignored (treated as 0).
- dst_addr  in  32  destination byte address; bits[1:0] ignored.
- len_words  in  LEN_W  number of words to copy.
- abort  in  1  stop after the outstanding transaction.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a copy (normal or aborted).
- aborted  out  1  copy ended by abort; held until the next accepted start.
- words_done  out  LEN_W  count of completed writes for the current/last copy.
- mem_valid  out  1  transaction request.
- mem_ready  in  1  responder completion, one cycle.
- mem_addr  out  32  word-aligned address (bits[1:0]=0).
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b0000 for read, 4'b1111 for write.
- mem_rdata  in  32  read data, valid in the mem_ready cycle.

Behaviour:
- Reset (async, immediate): state=IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; busy=0, done=0, aborted=0, words_done=0; internal src/dst/count/buffer=0. All outputs are registered.
- States: IDLE, RD, RD_GAP, WR, NEXT, DONE.
- IDLE:
  - start=1 → latch src, dst and len.
  - Clear aborted and words_done.
  - Go to RD if len!=0, else DONE.
- RD: mem_valid=1, mem_addr={src[31:2],2'b00}, mem_wstrb=0000. Hold until mem_ready=1; in that cycle capture mem_rdata into the buffer, then go to RD_GAP.
- RD_GAP: mem_valid=0 for exactly one cycle.
  - Go to DONE if abort was seen during RD/RD_GAP (no write of this word).
  - Otherwise go to WR.
- WR: mem_valid=1, mem_addr={dst[31:2],2'b00}, mem_wdata=buffer, mem_wstrb=1111. Hold until mem_ready=1, then:
  - words_done += 1
  - src += 4, dst += 4, count -= 1
  - Go to DONE if count reaches 0 or abort is pending, else NEXT.
- NEXT: mem_valid=0 for one cycle, then RD.
- DONE: mem_valid=0, done=1 for one cycle, aborted=1 if the copy ended by abort, then IDLE.
- Handshake rules:
  - mem_addr, mem_wdata and mem_wstrb are stable for every cycle mem_valid=1.
  - mem_valid is never dropped before mem_ready.
  - mem_valid is low for at least one cycle between transactions.
  - mem_ready while mem_valid=0 is ignored.
- abort:
  - Abort is level-sampled each cycle while busy and latched in a pending flag.
  - It never truncates a handshake.
  - Abort in IDLE has no effect.
- start while busy: ignored. len_words, src_addr and dst_addr changing mid-copy: ignored (latched copies used).
- Address arithmetic: 32-bit modulo, so 0xFFFFFFFC + 4 wraps to 0x00000000.
- Copy is always ascending; overlapping regions are not corrected.
- Timing, with a responder asserting mem_ready on the N-th cycle of mem_valid:
  - Each word takes 2N+2 cycles.
  - First mem_valid appears the cycle after start.
  - done appears in cycle (2N+2)·L counted from the start cycle (cycle 0).
  - With the BRAM controller, N=4, so 10 cycles per word.
- len_words=0: done in cycle 1, no mem_valid ever asserted.
- Reset mid-transaction: mem_valid drops asynchronously; the partial transaction is abandoned. The responder is reset by the same reset.

Test Plan:
- BRAM-model responder (N=4) preloaded 0x100..0x108 = 0x11111111/0x22222222/0x33333333; start src=0x100 dst=0x200 len=3 -> dst words match, done in cycle 30, words_done=3, aborted=0, busy falls with done.
- len=0 -> done pulse in cycle 1, mem_valid never high, words_done=0.
- Second start pulsed while busy during a 2-word copy -> ignored (exactly 4 transactions); a later start after done runs normally.
- abort asserted during RD of word 2 of 4 -> read completes, no write of word 2; done, aborted=1, words_done=1. abort during WR of word 2 -> write completes; words_done=2, aborted=1.
- Responder with N=1 and N=7 -> addr/wdata/wstrb stable while valid, ≥1 idle cycle between transactions, per-word latency 4 and 16 cycles.
- src=0xFFFFFFFC len=2 -> second read at 0x00000000. Async reset asserted mid-WR -> mem_valid, busy, done = 0 immediately, with no clock edge needed.
